shift_sequencer: RTL and testbench

//   Controller for the combinational bi-directional shifter datapath (LEN bits, +/-MAX_SHIFT_MAG per pass).
//   - Accepts a word, a direction and a shift amount of up to 2^AMT_W-1 over a valid/ready handshake.
//   - Splits the amount into passes of at most MAX_SHIFT_MAG.
//   - Drives the shifter's one-hot magnitude select once per cycle and registers each pass result.
//   - Presents the final word on an output valid/ready handshake.
//   - Processes one operation at a time.
//   - Sits between the requesting pipeline stage and one external shifter instance.

---
 rtl/shift_sequencer_if.sv | 30 +++
 rtl/shift_sequencer.sv | 98 +++++++++
 tb/tb_shift_sequencer.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/shift_sequencer_if.sv
// Handshake and shifter-side signals for shift_sequencer.
// The slave modport is the sequencer; the master modport is the surrounding pipeline plus shifter.
interface shift_sequencer_if #(
    parameter int LEN           = 8,
    parameter int MAX_SHIFT_MAG = 2,
    parameter int AMT_W         = 4
);
    logic                     in_valid;
    logic                     in_ready;
    logic [0:LEN-1]           in_data;
    logic                     in_dir;
    logic [AMT_W-1:0]         in_amt;
    logic                     out_valid;
    logic                     out_ready;
    logic [0:LEN-1]           out_data;
    logic [0:LEN-1]           sh_data;
    logic [0:2*MAX_SHIFT_MAG] sh_mag;
    logic [0:LEN-1]           sh_result;
    logic                     busy;

    modport slave (
        input  in_valid, in_data, in_dir, in_amt, out_ready, sh_result,
        output in_ready, out_valid, out_data, sh_data, sh_mag, busy
    );

    modport master (
        output in_valid, in_data, in_dir, in_amt, out_ready, sh_result,
        input  in_ready, out_valid, out_data, sh_data, sh_mag, busy
    );
endinterface

// File: rtl/shift_sequencer.sv
// Multi-pass controller for an external +/-MAX_SHIFT_MAG shifter: splits a shift amount into
// passes, registers each pass result and returns the final word over a valid/ready handshake.
module shift_sequencer #(
    parameter int LEN           = 8,
    parameter int MAX_SHIFT_MAG = 2,
    parameter int AMT_W         = 4
) (
    input  logic              clk,
    input  logic              rst,
    shift_sequencer_if.slave  bus
);
    typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;

    localparam logic [AMT_W-1:0] L_MAX = AMT_W'(MAX_SHIFT_MAG);
    localparam logic [AMT_W-1:0] L_LEN = AMT_W'(LEN);

    state_t                   r_state;
    state_t                   w_next_state;
    logic [0:LEN-1]           r_data;
    logic [AMT_W-1:0]         r_rem;
    logic                     r_dir;
    logic [AMT_W-1:0]         w_step;
    logic [AMT_W-1:0]         w_rem_next;
    logic [0:2*MAX_SHIFT_MAG] w_mag;
    logic                     w_bypass;

    assign w_step     = (r_rem < L_MAX) ? r_rem : L_MAX;
    assign w_rem_next = r_rem - w_step;
    // Zero amount or full-width shifts resolve without using the shifter.
    assign w_bypass   = (bus.in_amt == '0) || (bus.in_amt >= L_LEN);

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next_state;
    end

    always_comb begin
        w_next_state  = r_state;
        bus.in_ready  = 1'b0;
        bus.out_valid = 1'b0;
        bus.busy      = 1'b1;
        w_mag         = '0;
        case (r_state)
            S_IDLE: begin
                bus.in_ready = 1'b1;
                bus.busy     = 1'b0;
                w_mag[MAX_SHIFT_MAG] = 1'b1;
                if (bus.in_valid) w_next_state = w_bypass ? S_DONE : S_SHIFT;
            end
            S_SHIFT: begin
                // rem is never zero here, so exactly one select bit is raised.
                for (int i = 1; i <= MAX_SHIFT_MAG; i++) begin
                    if (w_step == AMT_W'(i)) begin
                        if (r_dir) w_mag[MAX_SHIFT_MAG + i] = 1'b1;
                        else       w_mag[MAX_SHIFT_MAG - i] = 1'b1;
                    end
                end
                if (w_rem_next == '0) w_next_state = S_DONE;
            end
            S_DONE: begin
                bus.out_valid = 1'b1;
                w_mag[MAX_SHIFT_MAG] = 1'b1;
                if (bus.out_ready) w_next_state = S_IDLE;
            end
            default: begin
                w_next_state = S_IDLE;
                w_mag[MAX_SHIFT_MAG] = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_data <= '0;
            r_rem  <= '0;
            r_dir  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.in_valid) begin
                        r_dir  <= bus.in_dir;
                        r_data <= (bus.in_amt >= L_LEN) ? '0 : bus.in_data;
                        if (!w_bypass) r_rem <= bus.in_amt;
                    end
                end
                S_SHIFT: begin
                    r_data <= bus.sh_result;
                    r_rem  <= w_rem_next;
                end
                default: ;
            endcase
        end
    end

    assign bus.out_data = r_data;
    assign bus.sh_data  = r_data;
    assign bus.sh_mag   = w_mag;
endmodule

// File: tb/tb_shift_sequencer.sv
// Randomized bench for shift_sequencer with a behavioural shifter and reference model.
module tb_shift_sequencer;
    localparam int LEN = 8;
    localparam int MAG = 2;
    localparam int AW  = 4;

    logic clk = 1'b0;
    logic rst;
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    shift_sequencer_if #(.LEN(LEN), .MAX_SHIFT_MAG(MAG), .AMT_W(AW)) bus();

    shift_sequencer #(.LEN(LEN), .MAX_SHIFT_MAG(MAG), .AMT_W(AW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // External shifter: the selected one-hot bit gives a signed offset.
    function automatic logic [0:LEN-1] shifter(input logic [0:LEN-1] d, input logic [0:2*MAG] m);
        logic [0:LEN-1] r;
        r = d;
        for (int i = 0; i <= 2*MAG; i++) begin
            if (m[i]) r = (i >= MAG) ? (d << (i - MAG)) : (d >> (MAG - i));
        end
        return r;
    endfunction

    always_comb bus.sh_result = shifter(bus.sh_data, bus.sh_mag);

    function automatic logic [0:LEN-1] ref_shift(input logic [0:LEN-1] d, input logic dir, input int k);
        if (k >= LEN) return '0;
        return dir ? (d << k) : (d >> k);
    endfunction

    function automatic logic [0:2*MAG] mag_onehot(input int off);
        logic [0:2*MAG] m;
        m = '0;
        m[MAG + off] = 1'b1;
        return m;
    endfunction

    task automatic do_reset();
        rst = 1'b1;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic run_op(input logic dir, input int amt, input logic [0:LEN-1] data, input int stall);
        logic [0:LEN-1] exp;
        int npass, exp_pass, rem, step;
        exp      = ref_shift(data, dir, amt);
        exp_pass = (amt == 0 || amt >= LEN) ? 0 : (amt + MAG - 1) / MAG;
        chk("idle_in_ready", bus.in_ready, 1);
        bus.in_valid = 1'b1;
        bus.in_dir   = dir;
        bus.in_amt   = AW'(amt);
        bus.in_data  = data;
        @(posedge clk); #1;
        // Junk on the input side while busy must be ignored.
        bus.in_dir    = 1'($urandom);
        bus.in_amt    = AW'($urandom);
        bus.in_data   = LEN'($urandom);
        bus.out_ready = 1'($urandom);
        rem   = amt;
        npass = 0;
        while (!bus.out_valid && npass < 40) begin
            if (npass < exp_pass) begin
                step = (rem < MAG) ? rem : MAG;
                rem -= step;
                chk("pass_mag", bus.sh_mag, mag_onehot(dir ? step : -step));
            end
            chk("pass_busy", bus.busy, 1);
            chk("pass_in_ready", bus.in_ready, 0);
            npass++;
            @(posedge clk); #1;
        end
        if (!bus.out_valid) begin
            chk("timeout", 0, 1);
            do_reset();
            return;
        end
        chk("passes", npass, exp_pass);
        chk("out_data", bus.out_data, exp);
        chk("done_mag", bus.sh_mag, mag_onehot(0));
        chk("done_in_ready", bus.in_ready, 0);
        chk("done_busy", bus.busy, 1);
        repeat (stall) begin
            bus.out_ready = 1'b0;
            @(posedge clk); #1;
            chk("hold_valid", bus.out_valid, 1);
            chk("hold_data", bus.out_data, exp);
            chk("hold_in_ready", bus.in_ready, 0);
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        chk("consumed_valid", bus.out_valid, 0);
        chk("resume_in_ready", bus.in_ready, 1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_dir    = 1'b0;
        bus.in_amt    = '0;
        bus.in_data   = '0;
        bus.out_ready = 1'b0;
        do_reset();
        chk("rst_in_ready", bus.in_ready, 1);
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_out_data", bus.out_data, 0);
        chk("rst_sh_mag", bus.sh_mag, mag_onehot(0));

        run_op(1'b1, 3, 8'b10110011, 0);
        run_op(1'b0, 5, 8'b11111111, 0);
        run_op(1'b0, 0, 8'b01011010, 0);
        run_op(1'b0, 8, 8'b11111111, 0);
        run_op(1'b1, 2, 8'b01011010, 4);

        // Reset during the second pass of a 5-place shift discards the operation.
        bus.in_valid = 1'b1;
        bus.in_dir   = 1'b1;
        bus.in_amt   = AW'(5);
        bus.in_data  = 8'b11001010;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        chk("mid_busy", bus.busy, 1);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("mrst_in_ready", bus.in_ready, 1);
        chk("mrst_out_valid", bus.out_valid, 0);
        chk("mrst_out_data", bus.out_data, 0);
        chk("mrst_sh_mag", bus.sh_mag, mag_onehot(0));
        repeat (3) begin
            @(posedge clk); #1;
            chk("mrst_no_output", bus.out_valid, 0);
        end

        for (int n = 0; n < 60; n++) begin
            run_op(1'($urandom), int'($urandom_range(0, 15)), LEN'($urandom), int'($urandom_range(0, 3)));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
